// File: rtl/pbl_ctrl_pkg.sv
// Shared control definitions for the PBL core: sequencer action codes and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: seq_act_t action enum, PBL_PC_WIDTH / PBL_STACK_DEPTH defaults shared with the decoder.
package pbl_ctrl_pkg;

   localparam int PBL_PC_WIDTH    = 5;
   localparam int PBL_STACK_DEPTH = 4;

   typedef enum logic [1:0] {
      SEQ    = 2'd0,
      JUMP   = 2'd1,
      CALL   = 2'd2,
      RETURN = 2'd3
   } seq_act_t;

   // Strobe priority ret > cal > jmp > sequential.
   function automatic seq_act_t pick_action(input logic ret, input logic cal, input logic jmp);
      if (ret)      return RETURN;
      else if (cal) return CALL;
      else if (jmp) return JUMP;
      else          return SEQ;
   endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO: DEPTH x W entries with a stack pointer counting occupied entries.
// Latency: push/pop take effect on the next rising edge; top_dat is combinational from sp.
// Backpressure: push while full and pop while empty are ignored (caller flags them).
// Ports: clk, rst_n (async, active low), push/pop strobes, push_dat in,
//        top_dat (entry at sp-1), sp (0..DEPTH), full, empty.
module ret_stack
   import pbl_ctrl_pkg::*;
#(
   parameter  int W     = PBL_PC_WIDTH,
   parameter  int DEPTH = PBL_STACK_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int SPW   = AW + 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           push,
   input  logic           pop,
   input  logic [W-1:0]   push_dat,
   output logic [W-1:0]   top_dat,
   output logic [SPW-1:0] sp,
   output logic           full,
   output logic           empty
);

   logic [W-1:0]   mem [DEPTH];
   logic [SPW-1:0] sp_m1;
   logic           do_push;
   logic           do_pop;

   assign full    = (sp == SPW'(DEPTH));
   assign empty   = (sp == '0);
   assign sp_m1   = sp - 1'b1;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty & ~push;

   // Entry below the pointer; meaningless while empty, and the caller ignores it then.
   assign top_dat = mem[sp_m1[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp <= '0;
      end else if (do_push) begin
         sp <= sp + 1'b1;
      end else if (do_pop) begin
         sp <= sp_m1;
      end
   end

   // Storage is deliberately left out of reset: sp alone defines what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[sp[AW-1:0]] <= push_dat;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with return-address stack and sticky overflow/underflow flags.
// Latency: new pc visible one edge after the strobe; all actions single-cycle.
// Backpressure: stall freezes pc, sp and stack and ignores strobes; err_clr still acts.
// Ports: clk, rst_n (async, active low), stall, jmp/cal/ret strobes, jmp_addr, err_clr in;
//        pc, sp, stack_full, stack_empty, overflow, underflow out.
// Build option: define PC_STACK_TRAP_EN to redirect pc to TRAP_ADDR on overflow/underflow.
module pc_sequencer
   import pbl_ctrl_pkg::*;
#(
   parameter  int PC_WIDTH    = PBL_PC_WIDTH,
   parameter  int STACK_DEPTH = PBL_STACK_DEPTH
`ifdef PC_STACK_TRAP_EN
   ,
   parameter  logic [PC_WIDTH-1:0] TRAP_ADDR = '1
`endif
   ,
   localparam int SPW = $clog2(STACK_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                jmp,
   input  logic                cal,
   input  logic                ret,
   input  logic [PC_WIDTH-1:0] jmp_addr,
   input  logic                err_clr,
   output logic [PC_WIDTH-1:0] pc,
   output logic [SPW-1:0]      sp,
   output logic                stack_full,
   output logic                stack_empty,
   output logic                overflow,
   output logic                underflow
);

   seq_act_t            act;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] pc_nxt;
   logic [PC_WIDTH-1:0] top_dat;
   logic                ovf_evt;
   logic                unf_evt;
   logic                push;
   logic                pop;

   assign act    = pick_action(ret, cal, jmp);
   assign pc_inc = pc + 1'b1;   // natural wrap at 2**PC_WIDTH

   assign ovf_evt = ~stall & (act == CALL)   & stack_full;
   assign unf_evt = ~stall & (act == RETURN) & stack_empty;
   assign push    = ~stall & (act == CALL)   & ~stack_full;
   assign pop     = ~stall & (act == RETURN) & ~stack_empty;

   ret_stack #(
      .W     (PC_WIDTH),
      .DEPTH (STACK_DEPTH)
   ) u_ret_stack (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .push_dat (pc_inc),
      .top_dat  (top_dat),
      .sp       (sp),
      .full     (stack_full),
      .empty    (stack_empty)
   );

   always_comb begin
      pc_nxt = pc_inc;
      unique case (act)
         SEQ:    pc_nxt = pc_inc;
         JUMP:   pc_nxt = jmp_addr;
`ifdef PC_STACK_TRAP_EN
         CALL:   pc_nxt = stack_full  ? TRAP_ADDR : jmp_addr;
         RETURN: pc_nxt = stack_empty ? TRAP_ADDR : top_dat;
`else
         CALL:   pc_nxt = jmp_addr;
         RETURN: pc_nxt = stack_empty ? pc_inc : top_dat;
`endif
         default: pc_nxt = pc_inc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
      end else if (!stall) begin
         pc <= pc_nxt;
      end
   end

   // A flag raised this cycle takes precedence over err_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_evt)      overflow  <= 1'b1;
         else if (err_clr) overflow  <= 1'b0;
         if (unf_evt)      underflow <= 1'b1;
         else if (err_clr) underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random strobes against a queue-based model.
// Latency: inputs applied at negedge, outputs compared at the following negedge.
// Backpressure: stall exercised both directed and at random.
module tb_pc_sequencer;

   localparam int PW  = 5;
   localparam int D   = 4;
   localparam int SPW = $clog2(D) + 1;
   localparam int PC_MOD = 1 << PW;
`ifdef PC_STACK_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   localparam int TRAP_PC = PC_MOD - 1;

   logic           clk;
   logic           rst_n;
   logic           stall;
   logic           jmp;
   logic           cal;
   logic           ret;
   logic [PW-1:0]  jmp_addr;
   logic           err_clr;
   logic [PW-1:0]  pc;
   logic [SPW-1:0] sp;
   logic           stack_full;
   logic           stack_empty;
   logic           overflow;
   logic           underflow;

   pc_sequencer #(
      .PC_WIDTH    (PW),
      .STACK_DEPTH (D)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .jmp         (jmp),
      .cal         (cal),
      .ret         (ret),
      .jmp_addr    (jmp_addr),
      .err_clr     (err_clr),
      .pc          (pc),
      .sp          (sp),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: return addresses in a queue, pc as a plain integer.
   int m_pc;
   int m_stack[$];
   bit m_ovf;
   bit m_unf;

   function automatic int nxt(input int p);
      return (p + 1) % PC_MOD;
   endfunction

   task automatic model_reset();
      m_pc = 0;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic model_edge(input bit s, input bit j, input bit c, input bit r,
                             input int a, input bit clr);
      bit set_o;
      bit set_u;
      set_o = 1'b0;
      set_u = 1'b0;
      if (!s) begin
         if (r) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin
               set_u = 1'b1;
               m_pc  = TRAP ? TRAP_PC : nxt(m_pc);
            end
         end else if (c) begin
            if (m_stack.size() < D) begin
               m_stack.push_back(nxt(m_pc));
               m_pc = a;
            end else begin
               set_o = 1'b1;
               m_pc  = TRAP ? TRAP_PC : a;
            end
         end else if (j) begin
            m_pc = a;
         end else begin
            m_pc = nxt(m_pc);
         end
      end
      if (clr) begin
         m_ovf = set_o;
         m_unf = set_u;
      end else begin
         m_ovf = m_ovf | set_o;
         m_unf = m_unf | set_u;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("pc",          32'(pc),          32'(m_pc));
      chk("sp",          32'(sp),          32'(m_stack.size()));
      chk("stack_full",  32'(stack_full),  32'(m_stack.size() == D));
      chk("stack_empty", 32'(stack_empty), 32'(m_stack.size() == 0));
      chk("overflow",    32'(overflow),    32'(m_ovf));
      chk("underflow",   32'(underflow),   32'(m_unf));
   endtask

   // Called at a negedge: apply inputs, let one rising edge pass, compare at the next negedge.
   task automatic step(input bit s, input bit j, input bit c, input bit r,
                       input int a, input bit clr);
      logic [31:0] av;
      av       = 32'(a);
      stall    = s;
      jmp      = j;
      cal      = c;
      ret      = r;
      jmp_addr = av[PW-1:0];
      err_clr  = clr;
      @(posedge clk);
      model_edge(s, j, c, r, a, clr);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      stall    = 1'b0;
      jmp      = 1'b0;
      cal      = 1'b0;
      ret      = 1'b0;
      jmp_addr = '0;
      err_clr  = 1'b0;
      model_reset();

      // Reset values, then sequential counting from 0.
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      repeat (6) idle();

      // Wrap 31 -> 0.
      step(0, 1, 0, 0, 31, 0);
      idle();

      // Plain jump from pc=3.
      step(0, 1, 0, 0, 3, 0);
      step(0, 1, 0, 0, 16, 0);

      // Call from pc=2 to 0x08, then return to 0x03.
      step(0, 1, 0, 0, 2, 0);
      step(0, 1, 1, 0, 8, 0);
      step(0, 0, 0, 1, 0, 0);

      // Four nested calls fill the stack, fifth overflows; clear; overflow beats same-cycle clear.
      step(0, 1, 1, 0, 4, 0);
      step(0, 1, 1, 0, 9, 0);
      step(0, 1, 1, 0, 14, 0);
      step(0, 1, 1, 0, 20, 0);
      step(0, 1, 1, 0, 26, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 1, 1, 0, 11, 1);
      step(1, 0, 0, 0, 0, 1);
      // Unwind all four entries.
      repeat (4) step(0, 0, 0, 1, 0, 0);

      // Return with an empty stack at pc=7.
      step(0, 1, 0, 0, 7, 0);
      step(0, 0, 0, 1, 0, 0);
      // ret beats cal when both strobe on an empty stack.
      step(0, 1, 1, 1, 5, 0);
      step(0, 0, 0, 0, 0, 1);

      // Stall with cal held: nothing moves, no flag set.
      step(0, 1, 1, 0, 12, 0);
      repeat (3) step(1, 1, 1, 0, 21, 0);

      // Async reset in the middle of a call cycle.
      stall    = 1'b0;
      jmp      = 1'b1;
      cal      = 1'b1;
      jmp_addr = 5'd21;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      check_all();
      jmp   = 1'b0;
      cal   = 1'b0;
      rst_n = 1'b1;
      idle();
      idle();

      // Random strobes, stalls and clears.
      for (int i = 0; i < 400; i++) begin
         bit s, j, c, r, clr;
         s   = ($urandom_range(0, 99) < 10);
         r   = ($urandom_range(0, 99) < 22);
         c   = ($urandom_range(0, 99) < 28);
         j   = c | ($urandom_range(0, 99) < 25);
         clr = ($urandom_range(0, 99) < 8);
         step(s, j, c, r, int'($urandom_range(0, PC_MOD - 1)), clr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
